// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants and helpers for the 640x480 @ 60 Hz display timing slice.
//   - default horizontal/vertical timing (pixels / lines) and derived totals
//   - counter width and counter type used for pixel_x / pixel_y
//   - sync polarity (VGA 640x480 uses active-low syncs)
//   - small helpers: inclusive window compare and wrapping increment
// -----------------------------------------------------------------------------
package vga_timing_pkg;

   localparam int unsigned CNT_W     = 10;

   localparam int unsigned H_VISIBLE = 640;
   localparam int unsigned H_FRONT   = 16;
   localparam int unsigned H_SYNC    = 96;
   localparam int unsigned H_BACK    = 48;
   localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

   localparam int unsigned V_VISIBLE = 480;
   localparam int unsigned V_FRONT   = 10;
   localparam int unsigned V_SYNC    = 2;
   localparam int unsigned V_BACK    = 33;
   localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // Level driven on hsync/vsync while the pulse is active.
   localparam logic SYNC_ACTIVE = 1'b0;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef struct packed {
      logic hsync;
      logic vsync;
   } sync_pair_t;

   // True when lo <= v <= hi (all operands are 10-bit counter values).
   function automatic logic in_window(input cnt_t v, input cnt_t lo, input cnt_t hi);
      return (v >= lo) && (v <= hi);
   endfunction

   // Increment a counter, returning to zero after 'last'.
   function automatic cnt_t wrap_inc(input cnt_t v, input cnt_t last);
      cnt_t r;
      if (v == last) begin
         r = {CNT_W{1'b0}};
      end else begin
         r = v + 10'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/vga_timing_if.sv
// -----------------------------------------------------------------------------
// vga_timing_if
// Bundle carrying the scan position, video-enable, strobes and syncs from the
// timing generator (master) to the paint stage / connector side (slave).
//   pixel_x, pixel_y : 10-bit scan position
//   vid_on           : position lies inside the visible 640x480 area
//   pixel_tick       : one-clock strobe, counters advance at the end of it
//   frame_start      : one-clock pulse when the position first reads (0,0)
//   hsync, vsync     : active-low syncs, already delayed for paint latency
// -----------------------------------------------------------------------------
interface vga_timing_if;
   import vga_timing_pkg::*;

   cnt_t pixel_x;
   cnt_t pixel_y;
   logic vid_on;
   logic pixel_tick;
   logic frame_start;
   logic hsync;
   logic vsync;

   modport master (
      output pixel_x, pixel_y, vid_on, pixel_tick, frame_start, hsync, vsync
   );

   modport slave (
      input pixel_x, pixel_y, vid_on, pixel_tick, frame_start, hsync, vsync
   );

endinterface

// File: rtl/vga_timing_sync_delay.sv
// -----------------------------------------------------------------------------
// sync_delay
// Fixed-depth shift register that re-times the sync pair so it lines up with
// the painter's registered colour. Runs on every clk (not pixel-gated).
//   clk  : system clock
//   rst  : asynchronous active-high reset, every stage loads all-ones
//   d_i  : undelayed sync bits
//   q_o  : d_i delayed by DEPTH clocks (wire pass-through when DEPTH == 0)
// -----------------------------------------------------------------------------
module sync_delay #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   if (DEPTH == 0) begin : g_bypass
      // Clock and reset are not needed when there is no storage.
      logic unused_ctrl_s;
      assign unused_ctrl_s = clk ^ rst;
      assign q_o           = d_i;
   end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];

      // Shift chain; idle (deasserted) sync level is loaded on reset.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
               stage_q[i] <= {WIDTH{1'b1}};
            end
         end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
               stage_q[i] <= stage_q[i-1];
            end
         end
      end

      assign q_o = stage_q[DEPTH-1];
   end

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// 640x480 @ 60 Hz scan timing from the 100 MHz system clock.
//   clk      : system clock (CLK_DIV clocks per pixel)
//   rst      : asynchronous active-high reset
//   timing_o : vga_timing_if master - pixel_x/pixel_y, vid_on, pixel_tick,
//              frame_start, hsync, vsync
// All outputs are registered. vid_on, frame_start and the undelayed syncs are
// computed from the next counter values so they switch on the same edge as
// the position. hsync/vsync then pass through SYNC_DELAY extra clocks so they
// stay aligned with the painter's registered colour.
// Reset parks the position at the last pixel of the frame so the first
// pixel_tick lands on (0,0) and raises frame_start.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned H_VISIBLE  = vga_timing_pkg::H_VISIBLE,
   parameter int unsigned H_FRONT    = vga_timing_pkg::H_FRONT,
   parameter int unsigned H_SYNC     = vga_timing_pkg::H_SYNC,
   parameter int unsigned H_BACK     = vga_timing_pkg::H_BACK,
   parameter int unsigned V_VISIBLE  = vga_timing_pkg::V_VISIBLE,
   parameter int unsigned V_FRONT    = vga_timing_pkg::V_FRONT,
   parameter int unsigned V_SYNC     = vga_timing_pkg::V_SYNC,
   parameter int unsigned V_BACK     = vga_timing_pkg::V_BACK,
   parameter int unsigned SYNC_DELAY = 1
) (
   input  logic          clk,
   input  logic          rst,
   vga_timing_if.master  timing_o
);
   import vga_timing_pkg::*;

   localparam int unsigned H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   localparam cnt_t ZERO     = 10'd0;
   localparam cnt_t H_LAST   = 10'(H_TOT - 1);
   localparam cnt_t V_LAST   = 10'(V_TOT - 1);
   localparam cnt_t H_VIS_C  = 10'(H_VISIBLE);
   localparam cnt_t V_VIS_C  = 10'(V_VISIBLE);
   localparam cnt_t HS_FIRST = 10'(H_VISIBLE + H_FRONT);
   localparam cnt_t HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam cnt_t VS_FIRST = 10'(V_VISIBLE + V_FRONT);
   localparam cnt_t VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic [DIV_W-1:0] div_q,  div_d;
   cnt_t             x_q,    x_d;
   cnt_t             y_q,    y_d;
   logic             tick_q, tick_d;
   logic             vid_q,  vid_d;
   logic             fs_q,   fs_d;
   logic             hs_q,   hs_d;
   logic             vs_q,   vs_d;
   logic             advance_s;
   sync_pair_t       sync_raw_s;
   sync_pair_t       sync_dly_s;

   // Next-state: divider, scan counters and outputs derived from the new position.
   always_comb begin
      div_d     = div_q;
      x_d       = x_q;
      y_d       = y_q;
      advance_s = 1'b0;

      if (div_q == DIV_LAST) begin
         div_d     = {DIV_W{1'b0}};
         advance_s = 1'b1;
      end else begin
         div_d     = div_q + DIV_W'(1);
         advance_s = 1'b0;
      end

      if (advance_s) begin
         x_d = wrap_inc(x_q, H_LAST);
         // The line counter only moves when the pixel counter wraps.
         if (x_q == H_LAST) begin
            y_d = wrap_inc(y_q, V_LAST);
         end else begin
            y_d = y_q;
         end
      end else begin
         x_d = x_q;
         y_d = y_q;
      end

      // Registered copy of (div == last) so pixel_tick is a flop output.
      tick_d = (div_d == DIV_LAST);
      vid_d  = (x_d < H_VIS_C) && (y_d < V_VIS_C);
      hs_d   = in_window(x_d, HS_FIRST, HS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      // vsync depends on the line only, never on the pixel column.
      vs_d   = in_window(y_d, VS_FIRST, VS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      // Only the edge that enters (0,0) raises it, so it lasts one clock.
      fs_d   = advance_s && (x_d == ZERO) && (y_d == ZERO);
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q  <= {DIV_W{1'b0}};
         x_q    <= H_LAST;
         y_q    <= V_LAST;
         tick_q <= 1'b0;
         vid_q  <= 1'b0;
         fs_q   <= 1'b0;
         hs_q   <= ~SYNC_ACTIVE;
         vs_q   <= ~SYNC_ACTIVE;
      end else begin
         div_q  <= div_d;
         x_q    <= x_d;
         y_q    <= y_d;
         tick_q <= tick_d;
         vid_q  <= vid_d;
         fs_q   <= fs_d;
         hs_q   <= hs_d;
         vs_q   <= vs_d;
      end
   end

   assign sync_raw_s.hsync = hs_q;
   assign sync_raw_s.vsync = vs_q;

   sync_delay #(
      .DEPTH (SYNC_DELAY),
      .WIDTH (2)
   ) u_sync_delay (
      .clk (clk),
      .rst (rst),
      .d_i (sync_raw_s),
      .q_o (sync_dly_s)
   );

   assign timing_o.pixel_x     = x_q;
   assign timing_o.pixel_y     = y_q;
   assign timing_o.vid_on      = vid_q;
   assign timing_o.pixel_tick  = tick_q;
   assign timing_o.frame_start = fs_q;
   assign timing_o.hsync       = sync_dly_s.hsync;
   assign timing_o.vsync       = sync_dly_s.vsync;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Four generators share clk/rst: default timing with sync delay 1, 0 and 3,
// plus a shrunken-frame instance so whole frames fit in a short run.
// Expected outputs come from a closed-form model indexed by the number of
// rising edges since reset release; they are queued per edge and popped when
// the outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       vid;
      logic       tick;
      logic       fs;
      logic       hs;
      logic       vs;
   } exp_t;

   typedef struct packed {
      int d;  int hv; int hf; int hs; int hb;
      int vv; int vf; int vs; int vb; int sd;
   } cfg_t;

   localparam cfg_t CFG_D1 = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 1};
   localparam cfg_t CFG_D0 = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 0};
   localparam cfg_t CFG_D3 = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 3};
   localparam cfg_t CFG_S  = '{2, 8, 2, 3, 2, 4, 1, 2, 2, 1};

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   exp_t sb_d1[$];
   exp_t sb_d0[$];
   exp_t sb_d3[$];
   exp_t sb_s[$];

   vga_timing_if vif_d1 ();
   vga_timing_if vif_d0 ();
   vga_timing_if vif_d3 ();
   vga_timing_if vif_s ();

   vga_timing_gen #(.SYNC_DELAY(1)) dut_d1 (.clk(clk), .rst(rst), .timing_o(vif_d1));
   vga_timing_gen #(.SYNC_DELAY(0)) dut_d0 (.clk(clk), .rst(rst), .timing_o(vif_d0));
   vga_timing_gen #(.SYNC_DELAY(3)) dut_d3 (.clk(clk), .rst(rst), .timing_o(vif_d3));
   vga_timing_gen #(
      .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_DELAY(1)
   ) dut_s (.clk(clk), .rst(rst), .timing_o(vif_s));

   exp_t obs_d1, obs_d0, obs_d3, obs_s;
   assign obs_d1 = {vif_d1.pixel_x, vif_d1.pixel_y, vif_d1.vid_on, vif_d1.pixel_tick,
                    vif_d1.frame_start, vif_d1.hsync, vif_d1.vsync};
   assign obs_d0 = {vif_d0.pixel_x, vif_d0.pixel_y, vif_d0.vid_on, vif_d0.pixel_tick,
                    vif_d0.frame_start, vif_d0.hsync, vif_d0.vsync};
   assign obs_d3 = {vif_d3.pixel_x, vif_d3.pixel_y, vif_d3.vid_on, vif_d3.pixel_tick,
                    vif_d3.frame_start, vif_d3.hsync, vif_d3.vsync};
   assign obs_s  = {vif_s.pixel_x, vif_s.pixel_y, vif_s.vid_on, vif_s.pixel_tick,
                    vif_s.frame_start, vif_s.hsync, vif_s.vsync};

   always #5 clk = ~clk;

   // Position after rising edge m (m counted from 0 after release; m < 0 = in reset).
   function automatic void pos_at(input int m, input int d, input int ht, input int vt,
                                  output int x, output int y);
      int q;
      if (m < 0) q = -1;
      else       q = (m + 1) / d - 1;
      if (q < 0) begin
         x = ht - 1;
         y = vt - 1;
      end else begin
         x = q % ht;
         y = (q / ht) % vt;
      end
   endfunction

   function automatic exp_t model(input int m, input cfg_t c);
      exp_t e;
      int   ht, vt, x, y, xs, ys;
      ht = c.hv + c.hf + c.hs + c.hb;
      vt = c.vv + c.vf + c.vs + c.vb;
      pos_at(m, c.d, ht, vt, x, y);
      e.x    = 10'(x);
      e.y    = 10'(y);
      e.vid  = (x < c.hv) && (y < c.vv);
      e.tick = (m >= 0) && (((m + 1) % c.d) == c.d - 1);
      e.fs   = (m >= 0) && (((m + 1) % c.d) == 0) && (x == 0) && (y == 0);
      pos_at(m - c.sd, c.d, ht, vt, xs, ys);
      e.hs   = !((xs >= c.hv + c.hf) && (xs < c.hv + c.hf + c.hs));
      e.vs   = !((ys >= c.vv + c.vf) && (ys < c.vv + c.vf + c.vs));
      return e;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      int   first_tick;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (obs_d1 !== model(-1, CFG_D1)) begin
         n_bad++;
         $display("FAIL reset_hold got=%h exp=%h", obs_d1, model(-1, CFG_D1));
      end
      n_cmp++;
      if (obs_d1.x !== 10'd799 || obs_d1.y !== 10'd524 || obs_d1.vid !== 1'b0 ||
          obs_d1.hs !== 1'b1 || obs_d1.vs !== 1'b1 || obs_d1.fs !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_values got=%h exp x=799 y=524 vid=0 fs=0 hs=1 vs=1", obs_d1);
      end
      @(negedge clk);
      rst = 1'b0;
      first_tick = -1;
      for (int m = 0; m < 12; m++) begin
         @(posedge clk);
         sb_d1.push_back(model(m, CFG_D1));
         #1;
         e = sb_d1.pop_front();
         n_cmp++;
         if (obs_d1 !== e) begin
            n_bad++;
            $display("FAIL release_seq clock=%0d got=%h exp=%h", m + 1, obs_d1, e);
         end
         if (first_tick < 0 && obs_d1.tick === 1'b1) first_tick = m + 1;
         if (m == 3) begin
            n_cmp++;
            if (obs_d1.x !== 10'd0 || obs_d1.y !== 10'd0 || obs_d1.vid !== 1'b1 ||
                obs_d1.fs !== 1'b1) begin
               n_bad++;
               $display("FAIL clock4_origin got=%h exp x=0 y=0 vid=1 fs=1", obs_d1);
            end
         end
         if (m == 4) begin
            n_cmp++;
            if (obs_d1.fs !== 1'b0) begin
               n_bad++;
               $display("FAIL clock5_fs_low got=%b exp=0", obs_d1.fs);
            end
         end
      end
      n_cmp++;
      if (first_tick !== 3) begin
         n_bad++;
         $display("FAIL first_tick got clock %0d exp clock 3", first_tick);
      end
   endtask

   task automatic test_line_wrap();
      exp_t e;
      int   x656_m, low_d1, low_d0, low_d3, low_cnt, wraps, px, py;
      x656_m = -1; low_d1 = -1; low_d0 = -1; low_d3 = -1;
      low_cnt = 0; wraps = 0; px = 0; py = 0;
      do_reset();
      for (int m = 0; m < 6420; m++) begin
         @(posedge clk);
         sb_d1.push_back(model(m, CFG_D1));
         sb_d0.push_back(model(m, CFG_D0));
         sb_d3.push_back(model(m, CFG_D3));
         #1;
         e = sb_d1.pop_front();
         n_cmp++;
         if (obs_d1 !== e) begin
            n_bad++;
            $display("FAIL line_d1 m=%0d got=%h exp=%h", m, obs_d1, e);
         end
         e = sb_d0.pop_front();
         n_cmp++;
         if (obs_d0 !== e) begin
            n_bad++;
            $display("FAIL line_d0 m=%0d got=%h exp=%h", m, obs_d0, e);
         end
         e = sb_d3.pop_front();
         n_cmp++;
         if (obs_d3 !== e) begin
            n_bad++;
            $display("FAIL line_d3 m=%0d got=%h exp=%h", m, obs_d3, e);
         end
         if (x656_m < 0 && obs_d1.x === 10'd656) x656_m = m;
         if (low_d1 < 0 && obs_d1.hs === 1'b0) low_d1 = m;
         if (low_d0 < 0 && obs_d0.hs === 1'b0) low_d0 = m;
         if (low_d3 < 0 && obs_d3.hs === 1'b0) low_d3 = m;
         if (m < 3200 && obs_d1.hs === 1'b0) low_cnt++;
         if (m > 3 && px == 799 && obs_d1.x === 10'd0) begin
            wraps++;
            n_cmp++;
            if (int'(obs_d1.y) != py + 1) begin
               n_bad++;
               $display("FAIL line_wrap_y m=%0d got=%0d exp=%0d", m, obs_d1.y, py + 1);
            end
         end
         px = int'(obs_d1.x);
         py = int'(obs_d1.y);
      end
      n_cmp++;
      if (wraps != 2) begin
         n_bad++;
         $display("FAIL line_wrap_count got=%0d exp=2", wraps);
      end
      n_cmp++;
      if (low_cnt != 384) begin
         n_bad++;
         $display("FAIL hsync_low_len got=%0d exp=384", low_cnt);
      end
      n_cmp++;
      if (x656_m < 0 || low_d1 - x656_m != 1) begin
         n_bad++;
         $display("FAIL hsync_d1_lag got=%0d exp=1", low_d1 - x656_m);
      end
      n_cmp++;
      if (x656_m < 0 || low_d0 - x656_m != 0) begin
         n_bad++;
         $display("FAIL hsync_d0_lag got=%0d exp=0", low_d0 - x656_m);
      end
      n_cmp++;
      if (x656_m < 0 || low_d3 - x656_m != 3) begin
         n_bad++;
         $display("FAIL hsync_d3_lag got=%0d exp=3", low_d3 - x656_m);
      end
   endtask

   task automatic test_frame();
      exp_t e;
      int   fs_m[$];
      int   vs_low, vid_clk, viol, ywraps, px, py;
      vs_low = 0; vid_clk = 0; viol = 0; ywraps = 0; px = 0; py = 0;
      do_reset();
      for (int m = 0; m < 820; m++) begin
         @(posedge clk);
         sb_s.push_back(model(m, CFG_S));
         #1;
         e = sb_s.pop_front();
         n_cmp++;
         if (obs_s !== e) begin
            n_bad++;
            $display("FAIL frame_seq m=%0d got=%h exp=%h", m, obs_s, e);
         end
         if (obs_s.fs === 1'b1) fs_m.push_back(m);
         if (fs_m.size() == 1) begin
            if (obs_s.vs === 1'b0) vs_low++;
            if (obs_s.vid === 1'b1) vid_clk++;
         end
         if (obs_s.vid === 1'b1 && (obs_s.x >= 10'd8 || obs_s.y >= 10'd4)) viol++;
         if (m > 3 && py == 8 && obs_s.y === 10'd0) begin
            ywraps++;
            n_cmp++;
            if (px != 14 || obs_s.x !== 10'd0) begin
               n_bad++;
               $display("FAIL frame_wrap_x m=%0d got prev=%0d now=%0d exp 14->0", m, px, obs_s.x);
            end
         end
         px = int'(obs_s.x);
         py = int'(obs_s.y);
      end
      n_cmp++;
      if (fs_m.size() != 4) begin
         n_bad++;
         $display("FAIL frame_start_count got=%0d exp=4", fs_m.size());
      end
      n_cmp++;
      if (fs_m.size() < 3 || fs_m[1] - fs_m[0] != 270 || fs_m[2] - fs_m[1] != 270) begin
         n_bad++;
         $display("FAIL frame_period got fs count=%0d exp spacing 270", fs_m.size());
      end
      n_cmp++;
      if (vs_low != 60) begin
         n_bad++;
         $display("FAIL vsync_low_len got=%0d exp=60", vs_low);
      end
      n_cmp++;
      if (vid_clk != 64) begin
         n_bad++;
         $display("FAIL vid_on_clocks got=%0d exp=64", vid_clk);
      end
      n_cmp++;
      if (viol != 0) begin
         n_bad++;
         $display("FAIL vid_on_outside got=%0d exp=0", viol);
      end
      n_cmp++;
      if (ywraps != 3) begin
         n_bad++;
         $display("FAIL frame_wrap_count got=%0d exp=3", ywraps);
      end
   endtask

   task automatic test_async_reset();
      exp_t e;
      bit   found;
      found = 1'b0;
      do_reset();
      for (int m = 0; m < 400 && !found; m++) begin
         @(posedge clk);
         #1;
         if (obs_s.x === 10'd5 && obs_s.y === 10'd3) found = 1'b1;
      end
      n_cmp++;
      if (!found) begin
         n_bad++;
         $display("FAIL async_reach got=timeout exp=(5,3)");
      end
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (obs_s.x !== 10'd14 || obs_s.y !== 10'd8 || obs_s.vid !== 1'b0 ||
          obs_s.hs !== 1'b1 || obs_s.vs !== 1'b1 || obs_s.fs !== 1'b0 || obs_s.tick !== 1'b0) begin
         n_bad++;
         $display("FAIL async_small got=%h exp x=14 y=8 vid=0 tick=0 fs=0 hs=1 vs=1", obs_s);
      end
      n_cmp++;
      if (obs_d1.x !== 10'd799 || obs_d1.y !== 10'd524 || obs_d1.vid !== 1'b0 ||
          obs_d1.hs !== 1'b1 || obs_d1.vs !== 1'b1) begin
         n_bad++;
         $display("FAIL async_default got=%h exp x=799 y=524 vid=0 hs=1 vs=1", obs_d1);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int m = 0; m < 12; m++) begin
         @(posedge clk);
         sb_d1.push_back(model(m, CFG_D1));
         sb_s.push_back(model(m, CFG_S));
         #1;
         e = sb_d1.pop_front();
         n_cmp++;
         if (obs_d1 !== e) begin
            n_bad++;
            $display("FAIL rerelease_d1 clock=%0d got=%h exp=%h", m + 1, obs_d1, e);
         end
         e = sb_s.pop_front();
         n_cmp++;
         if (obs_s !== e) begin
            n_bad++;
            $display("FAIL rerelease_small clock=%0d got=%h exp=%h", m + 1, obs_s, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_line_wrap();
      test_frame();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
